v_issue_stage: RTL and testbench

//  Pipelined, parametrised vector decode/issue stage between the instruction fetch and the VALU/VMEM units.
//  It accepts instructions over a valid/ready handshake and decodes them in stage D.
//  It reads the vector and scalar register files, applies SEW widening and broadcast, and checks a per-register busy scoreboard.

---
 rtl/v_issue_stage_if.sv | 35 +++
 rtl/v_issue_stage.sv | 259 +++++++++++++++++++++++++
 tb/tb_v_issue_stage.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/v_issue_stage_if.sv
// Issue-side bundle between the vector decode/issue stage and the VALU/VMEM execute units.
// The stage drives everything except iss_ready, which the execute side returns.
interface v_issue_stage_if #(
  parameter int VREG_DW   = 512,
  parameter int VREG_AW   = 5,
  parameter int VALUOP_DW = 5,
  parameter int VMEM_AW   = 64
);
  logic                 iss_valid;
  logic                 iss_ready;
  logic [VALUOP_DW-1:0] valu_opcode;
  logic [VREG_DW-1:0]   operand_v1;
  logic [VREG_DW-1:0]   operand_v2;
  logic                 vmem_ren;
  logic                 vmem_wen;
  logic [VMEM_AW-1:0]   vmem_addr;
  logic [VREG_DW-1:0]   vmem_din;
  logic                 vid_wb_en;
  logic                 vid_wb_sel;
  logic [VREG_AW-1:0]   vid_wb_addr;

  modport master (
    output iss_valid, valu_opcode, operand_v1, operand_v2,
           vmem_ren, vmem_wen, vmem_addr, vmem_din,
           vid_wb_en, vid_wb_sel, vid_wb_addr,
    input  iss_ready
  );

  modport slave (
    input  iss_valid, valu_opcode, operand_v1, operand_v2,
           vmem_ren, vmem_wen, vmem_addr, vmem_din,
           vid_wb_en, vid_wb_sel, vid_wb_addr,
    output iss_ready
  );
endinterface

// File: rtl/v_issue_stage.sv
// Two-stage vector decode (D) / issue (I) pipeline with register-file reads, SEW widening,
// scalar/immediate broadcast and a per-vector-register busy scoreboard.
module v_issue_stage #(
  parameter int INST_DW   = 32,
  parameter int REG_DW    = 64,
  parameter int REG_AW    = 5,
  parameter int VREG_DW   = 512,
  parameter int VREG_AW   = 5,
  parameter int VALUOP_DW = 5,
  parameter int VMEM_AW   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    inst_valid_i,
  input  logic [INST_DW-1:0]      inst_i,
  output logic                    inst_ready_o,
  output logic                    rs1_en_o,
  output logic [REG_AW-1:0]       rs1_addr_o,
  input  logic [REG_DW-1:0]       rs1_dout_i,
  output logic                    vs1_en_o,
  output logic [VREG_AW-1:0]      vs1_addr_o,
  input  logic [VREG_DW-1:0]      vs1_dout_i,
  output logic                    vs2_en_o,
  output logic [VREG_AW-1:0]      vs2_addr_o,
  input  logic [VREG_DW-1:0]      vs2_dout_i,
  v_issue_stage_if.master         iss_if,
  input  logic                    wb_valid_i,
  input  logic [VREG_AW-1:0]      wb_addr_i,
  output logic                    illegal_o,
  output logic [2**VREG_AW-1:0]   busy_o
);

  localparam int NREG = 2**VREG_AW;

  localparam logic [6:0] OPC_LOAD  = 7'b0000111;
  localparam logic [6:0] OPC_STORE = 7'b0100111;
  localparam logic [6:0] OPC_ARITH = 7'b1010111;
  localparam logic [2:0] F3_VV     = 3'b000;
  localparam logic [2:0] F3_VX     = 3'b100;
  localparam logic [2:0] F3_VI     = 3'b011;

  function automatic logic [VREG_DW-1:0] widen_8_16(input logic [VREG_DW-1:0] v);
    logic [VREG_DW-1:0] r;
    r = '0;
    for (int k = 0; k < VREG_DW/16; k++)
      r[16*k +: 16] = {{8{v[8*k+7]}}, v[8*k +: 8]};
    return r;
  endfunction

  function automatic logic [VREG_DW-1:0] widen_16_32(input logic [VREG_DW-1:0] v);
    logic [VREG_DW-1:0] r;
    r = '0;
    for (int k = 0; k < VREG_DW/32; k++)
      r[32*k +: 32] = {{16{v[16*k+15]}}, v[16*k +: 16]};
    return r;
  endfunction

  // s already holds the value sign-extended to 32 bits, so a 16-bit lane is just its low half.
  function automatic logic [VREG_DW-1:0] bcast(input logic [31:0] s, input logic ew16);
    logic [VREG_DW-1:0] r;
    r = '0;
    for (int k = 0; k < VREG_DW/32; k++)
      r[32*k +: 32] = ew16 ? {2{s[15:0]}} : s;
    return r;
  endfunction

  logic                 d_valid_q, d_valid_d;
  logic [INST_DW-1:0]   d_inst_q, d_inst_d;
  logic                 i_valid_q, i_valid_d;
  logic [VALUOP_DW-1:0] op_q, op_d;
  logic [VREG_DW-1:0]   v1_q, v1_d, v2_q, v2_d, din_q, din_d;
  logic                 ren_q, ren_d, wen_q, wen_d;
  logic [VMEM_AW-1:0]   addr_q, addr_d;
  logic                 wb_en_q, wb_en_d, wb_sel_q, wb_sel_d;
  logic [VREG_AW-1:0]   wb_addr_q, wb_addr_d;
  logic [NREG-1:0]      busy_q, busy_d;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  vd_f, rs_f, vs2_f;
  logic        is_ld, is_st, is_ar, ar_vv, ar_vx, ar_vi, ar_ok, dec_ok;
  logic        res16, wide8, wide16;
  logic        d_illegal, hazard, d_adv, accept, wb_en_dec;
  logic [VREG_AW-1:0] vd_a;
  logic [31:0] scalar32, imm32;
  logic [VREG_DW-1:0] vs1_w, vs2_w;

  assign opc   = d_inst_q[6:0];
  assign vd_f  = d_inst_q[11:7];
  assign f3    = d_inst_q[14:12];
  assign rs_f  = d_inst_q[19:15];
  assign vs2_f = d_inst_q[24:20];
  assign f7    = d_inst_q[31:25];
  assign vd_a  = VREG_AW'(vd_f);

  always_comb begin
    is_ld  = (opc == OPC_LOAD);
    is_st  = (opc == OPC_STORE);
    is_ar  = (opc == OPC_ARITH);
    ar_vv  = (f3 == F3_VV);
    ar_vx  = (f3 == F3_VX);
    ar_vi  = (f3 == F3_VI);
    // Reductions (11,12) and pool (13) exist only in the vector-vector form.
    ar_ok  = is_ar && (f7 <= 7'd13) && (ar_vv || ((ar_vx || ar_vi) && (f7 < 7'd11)));
    dec_ok = is_ld || is_st || ar_ok;
    wide8  = (f7 == 7'd0);
    wide16 = (f7 == 7'd4);
    res16  = (f7 == 7'd0) || (f7 == 7'd1) || (f7 == 7'd2) || (f7 == 7'd3) || (f7 == 7'd13);
    wb_en_dec = is_ld || ar_ok;
  end

  always_comb begin
    rs1_en_o   = d_valid_q && (is_ld || is_st || (ar_ok && ar_vx));
    rs1_addr_o = REG_AW'(rs_f);
    vs1_en_o   = d_valid_q && ar_ok && ar_vv;
    vs1_addr_o = VREG_AW'(rs_f);
    vs2_en_o   = d_valid_q && (is_st || ar_ok);
    vs2_addr_o = is_st ? vd_a : VREG_AW'(vs2_f);
  end

  // busy_q is the registered scoreboard, so a clear in this cycle only unblocks next cycle.
  assign hazard = (vs1_en_o && busy_q[vs1_addr_o]) ||
                  (vs2_en_o && busy_q[vs2_addr_o]) ||
                  (d_valid_q && wb_en_dec && busy_q[vd_a]);

  assign d_illegal    = d_valid_q && !dec_ok;
  assign d_adv        = d_valid_q && dec_ok && !hazard && (!i_valid_q || iss_if.iss_ready) && !flush_i;
  assign inst_ready_o = !d_valid_q || d_adv || d_illegal;
  assign accept       = inst_valid_i && inst_ready_o && !flush_i;
  assign illegal_o    = d_illegal && !flush_i;

  always_comb begin
    vs1_w = vs1_dout_i;
    vs2_w = vs2_dout_i;
    if (wide8) begin
      vs1_w = widen_8_16(vs1_dout_i);
      vs2_w = widen_8_16(vs2_dout_i);
    end else if (wide16) begin
      vs1_w = widen_16_32(vs1_dout_i);
      vs2_w = widen_16_32(vs2_dout_i);
    end
    if (wide8)
      scalar32 = {{24{rs1_dout_i[7]}}, rs1_dout_i[7:0]};
    else if (wide16 || res16)
      scalar32 = {{16{rs1_dout_i[15]}}, rs1_dout_i[15:0]};
    else
      scalar32 = rs1_dout_i[31:0];
    imm32 = {{27{rs_f[4]}}, rs_f};
  end

  always_comb begin
    op_d      = '0;
    v1_d      = '0;
    v2_d      = '0;
    ren_d     = is_ld;
    wen_d     = is_st;
    addr_d    = '0;
    din_d     = '0;
    wb_en_d   = wb_en_dec;
    wb_sel_d  = is_ld;
    wb_addr_d = vd_a;
    if (is_ld || is_st)
      addr_d = VMEM_AW'(rs1_dout_i);
    if (is_st)
      din_d = vs2_dout_i;
    if (ar_ok) begin
      op_d = VALUOP_DW'(f7 + 7'd1);
      v2_d = vs2_w;
      if (ar_vv)
        v1_d = vs1_w;
      else if (ar_vx)
        v1_d = bcast(scalar32, res16 && !wide16);
      else
        v1_d = bcast(imm32, res16 && !wide16);
    end
  end

  always_comb begin
    d_valid_d = d_valid_q;
    d_inst_d  = d_inst_q;
    if (flush_i)
      d_valid_d = 1'b0;
    else if (accept) begin
      d_valid_d = 1'b1;
      d_inst_d  = inst_i;
    end else if (d_adv || d_illegal)
      d_valid_d = 1'b0;

    i_valid_d = i_valid_q;
    if (flush_i)
      i_valid_d = 1'b0;
    else if (d_adv)
      i_valid_d = 1'b1;
    else if (iss_if.iss_ready)
      i_valid_d = 1'b0;

    // Set is applied after clear so a same-address collision leaves the register busy.
    busy_d = busy_q;
    if (wb_valid_i)
      busy_d[wb_addr_i] = 1'b0;
    if (d_adv && wb_en_dec)
      busy_d[vd_a] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_valid_q <= 1'b0;
      d_inst_q  <= '0;
      i_valid_q <= 1'b0;
      busy_q    <= '0;
    end else begin
      d_valid_q <= d_valid_d;
      d_inst_q  <= d_inst_d;
      i_valid_q <= i_valid_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= '0;
      v1_q      <= '0;
      v2_q      <= '0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      wb_en_q   <= 1'b0;
      wb_sel_q  <= 1'b0;
      wb_addr_q <= '0;
    end else if (d_adv) begin
      op_q      <= op_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      ren_q     <= ren_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      wb_en_q   <= wb_en_d;
      wb_sel_q  <= wb_sel_d;
      wb_addr_q <= wb_addr_d;
    end
  end

  assign iss_if.iss_valid   = i_valid_q;
  assign iss_if.valu_opcode = op_q;
  assign iss_if.operand_v1  = v1_q;
  assign iss_if.operand_v2  = v2_q;
  assign iss_if.vmem_ren    = ren_q;
  assign iss_if.vmem_wen    = wen_q;
  assign iss_if.vmem_addr   = addr_q;
  assign iss_if.vmem_din    = din_q;
  assign iss_if.vid_wb_en   = wb_en_q;
  assign iss_if.vid_wb_sel  = wb_sel_q;
  assign iss_if.vid_wb_addr = wb_addr_q;
  assign busy_o             = busy_q;

endmodule

// File: tb/tb_v_issue_stage.sv
// Bench for v_issue_stage: directed scenarios plus a randomized run checked against an
// instruction-level reference model of decode, operand shaping and in-order issue.
module tb_v_issue_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush_i;
  logic         inst_valid_i;
  logic [31:0]  inst_i;
  logic         inst_ready_o;
  logic         rs1_en_o, vs1_en_o, vs2_en_o;
  logic [4:0]   rs1_addr_o, vs1_addr_o, vs2_addr_o;
  logic [63:0]  rs1_dout_i;
  logic [511:0] vs1_dout_i, vs2_dout_i;
  logic         wb_valid_i;
  logic [4:0]   wb_addr_i;
  logic         illegal_o;
  logic [31:0]  busy_o;

  v_issue_stage_if #(.VREG_DW(512), .VREG_AW(5), .VALUOP_DW(5), .VMEM_AW(64)) iss_if ();

  v_issue_stage dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .inst_valid_i(inst_valid_i), .inst_i(inst_i), .inst_ready_o(inst_ready_o),
    .rs1_en_o(rs1_en_o), .rs1_addr_o(rs1_addr_o), .rs1_dout_i(rs1_dout_i),
    .vs1_en_o(vs1_en_o), .vs1_addr_o(vs1_addr_o), .vs1_dout_i(vs1_dout_i),
    .vs2_en_o(vs2_en_o), .vs2_addr_o(vs2_addr_o), .vs2_dout_i(vs2_dout_i),
    .iss_if(iss_if.master),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i),
    .illegal_o(illegal_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  logic [511:0] vrf [32];
  logic [63:0]  srf [32];
  assign rs1_dout_i = srf[rs1_addr_o];
  assign vs1_dout_i = vrf[vs1_addr_o];
  assign vs2_dout_i = vrf[vs2_addr_o];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit           legal;
    logic [4:0]   op;
    logic [511:0] v1, v2, din;
    logic [63:0]  addr;
    logic         ren, wen, wb_en, sel;
    logic [4:0]   wb_addr;
  } exp_t;

  function automatic logic [31:0] enc(input int f7, input int vs2, input int rs,
                                      input int f3, input int vd, input logic [6:0] opc);
    return {7'(f7), 5'(vs2), 5'(rs), 3'(f3), 5'(vd), opc};
  endfunction

  function automatic logic [511:0] m_widen(input logic [511:0] v, input int src_ew);
    logic [511:0] r = '0;
    int e;
    if (src_ew == 8) begin
      for (int k = 0; k < 32; k++) begin
        e = $signed(v[8*k +: 8]);
        r[16*k +: 16] = e[15:0];
      end
    end else begin
      for (int k = 0; k < 16; k++) begin
        e = $signed(v[16*k +: 16]);
        r[32*k +: 32] = e;
      end
    end
    return r;
  endfunction

  function automatic logic [511:0] m_bcast(input int val, input int ew);
    logic [511:0] r = '0;
    for (int k = 0; k < 512/ew; k++) begin
      if (ew == 16) r[16*k +: 16] = val[15:0];
      else          r[32*k +: 32] = val;
    end
    return r;
  endfunction

  function automatic exp_t predict(input logic [31:0] in);
    exp_t x;
    int f7, f3, rs, vd, vs2, res_ew, src_ew, sval;
    logic [63:0] s;
    f7 = int'(in[31:25]); vs2 = int'(in[24:20]); rs = int'(in[19:15]);
    f3 = int'(in[14:12]); vd = int'(in[11:7]);
    x = '{legal: 1'b0, op: '0, v1: '0, v2: '0, din: '0, addr: '0,
          ren: 1'b0, wen: 1'b0, wb_en: 1'b0, sel: 1'b0, wb_addr: 5'(vd)};
    if (in[6:0] == 7'b0000111) begin
      x.legal = 1; x.ren = 1; x.addr = srf[rs]; x.wb_en = 1; x.sel = 1;
    end else if (in[6:0] == 7'b0100111) begin
      x.legal = 1; x.wen = 1; x.addr = srf[rs]; x.din = vrf[vd];
    end else if (in[6:0] == 7'b1010111 && f7 <= 13 &&
                 (f3 == 0 || ((f3 == 4 || f3 == 3) && f7 < 11))) begin
      x.legal = 1; x.wb_en = 1; x.op = 5'(f7 + 1);
      res_ew = (f7 inside {0, 1, 2, 3, 13}) ? 16 : 32;
      src_ew = (f7 == 0) ? 8 : (f7 == 4) ? 16 : res_ew;
      x.v2 = (src_ew != res_ew) ? m_widen(vrf[vs2], src_ew) : vrf[vs2];
      if (f3 == 0) begin
        x.v1 = (src_ew != res_ew) ? m_widen(vrf[rs], src_ew) : vrf[rs];
      end else if (f3 == 4) begin
        s = srf[rs];
        if (src_ew == 8)       sval = $signed(s[7:0]);
        else if (src_ew == 16) sval = $signed(s[15:0]);
        else                   sval = $signed(s[31:0]);
        x.v1 = m_bcast(sval, res_ew);
      end else begin
        sval = $signed(in[19:15]);
        x.v1 = m_bcast(sval, res_ew);
      end
    end
    return x;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] in);
    bit acc = 0;
    inst_valid_i = 1; inst_i = in;
    for (int c = 0; c < 100 && !acc; c++) begin
      @(negedge clk); acc = inst_ready_o;
      step();
    end
    inst_valid_i = 0;
    n_checks++;
    if (!acc) begin n_fail++; $display("FAIL send_timeout: inst %h never accepted, ready=%b", in, inst_ready_o); end
  endtask

  task automatic retire(input int r);
    wb_valid_i = 1; wb_addr_i = 5'(r);
    step();
    wb_valid_i = 0;
  endtask

  task automatic test_reset();
    n_checks += 6;
    if (iss_if.iss_valid !== 1'b0) begin n_fail++; $display("FAIL reset_iss_valid: got %b want 0", iss_if.iss_valid); end
    if (busy_o !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy_o); end
    if (illegal_o !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal_o); end
    if (inst_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_inst_ready: got %b want 1", inst_ready_o); end
    if (iss_if.valu_opcode !== 5'd0 || iss_if.vid_wb_en !== 1'b0 || iss_if.vmem_ren !== 1'b0)
      begin n_fail++; $display("FAIL reset_ctrl: got op=%h wb=%b ren=%b want 0", iss_if.valu_opcode, iss_if.vid_wb_en, iss_if.vmem_ren); end
    if (iss_if.operand_v1 !== '0 || iss_if.vmem_addr !== '0)
      begin n_fail++; $display("FAIL reset_data: got v1=%h addr=%h want 0", iss_if.operand_v1, iss_if.vmem_addr); end
  endtask

  task automatic test_vadd();
    iss_if.iss_ready = 1;
    send(enc(5, 2, 1, 0, 3, 7'b1010111));
    n_checks += 2;
    if (iss_if.iss_valid !== 1'b0) begin n_fail++; $display("FAIL vadd_early: iss_valid=%b want 0", iss_if.iss_valid); end
    if (busy_o !== 32'h0) begin n_fail++; $display("FAIL vadd_busy_early: got %h want 0", busy_o); end
    step();
    n_checks += 5;
    if (iss_if.iss_valid !== 1'b1) begin n_fail++; $display("FAIL vadd_latency: iss_valid=%b want 1", iss_if.iss_valid); end
    if (iss_if.valu_opcode !== 5'd6) begin n_fail++; $display("FAIL vadd_op: got %0d want 6", iss_if.valu_opcode); end
    if (iss_if.operand_v1 !== vrf[1] || iss_if.operand_v2 !== vrf[2])
      begin n_fail++; $display("FAIL vadd_operands: got v1=%h want %h", iss_if.operand_v1, vrf[1]); end
    if (iss_if.vid_wb_en !== 1'b1 || iss_if.vid_wb_sel !== 1'b0 || iss_if.vid_wb_addr !== 5'd3)
      begin n_fail++; $display("FAIL vadd_wb: got en=%b sel=%b addr=%0d want 1 0 3", iss_if.vid_wb_en, iss_if.vid_wb_sel, iss_if.vid_wb_addr); end
    if (busy_o !== 32'h8) begin n_fail++; $display("FAIL vadd_busy_set: got %h want 8", busy_o); end
    step();
    n_checks += 2;
    if (iss_if.iss_valid !== 1'b0) begin n_fail++; $display("FAIL vadd_drain: iss_valid=%b want 0", iss_if.iss_valid); end
    if (busy_o !== 32'h8) begin n_fail++; $display("FAIL vadd_busy_hold: got %h want 8", busy_o); end
    retire(3);
    n_checks++;
    if (busy_o !== 32'h0) begin n_fail++; $display("FAIL vadd_busy_clear: got %h want 0", busy_o); end
  endtask

  task automatic test_widen_vx();
    exp_t e;
    logic [31:0] in;
    vrf[2][7:0] = 8'h7F; vrf[2][15:8] = 8'h81;
    srf[5] = 64'h1234_5678_9ABC_DE80;
    in = enc(0, 2, 5, 4, 6, 7'b1010111);
    e = predict(in);
    iss_if.iss_ready = 1;
    send(in);
    step();
    n_checks += 4;
    if (iss_if.operand_v1 !== {32{16'hFF80}}) begin n_fail++; $display("FAIL widen_scalar: got %h want 32x ff80", iss_if.operand_v1); end
    if (iss_if.operand_v2[31:0] !== 32'hFF81_007F) begin n_fail++; $display("FAIL widen_lanes01: got %h want ff81007f", iss_if.operand_v2[31:0]); end
    if (iss_if.operand_v2 !== e.v2) begin n_fail++; $display("FAIL widen_v2: got %h want %h", iss_if.operand_v2, e.v2); end
    if (iss_if.valu_opcode !== 5'd1) begin n_fail++; $display("FAIL widen_op: got %0d want 1", iss_if.valu_opcode); end
    step();
    retire(6);
  endtask

  task automatic test_raw_stall();
    iss_if.iss_ready = 1;
    send(enc(5, 2, 1, 0, 3, 7'b1010111));
    send(enc(7, 3, 5, 0, 4, 7'b1010111));
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks += 2;
      if (iss_if.iss_valid !== 1'b0) begin n_fail++; $display("FAIL raw_stall_issue: cycle %0d iss_valid=%b want 0", c, iss_if.iss_valid); end
      if (inst_ready_o !== 1'b0) begin n_fail++; $display("FAIL raw_stall_ready: cycle %0d inst_ready=%b want 0", c, inst_ready_o); end
    end
    retire(3);
    n_checks += 2;
    if (iss_if.iss_valid !== 1'b0) begin n_fail++; $display("FAIL raw_no_bypass: iss_valid=%b want 0 at clear edge", iss_if.iss_valid); end
    if (busy_o !== 32'h0) begin n_fail++; $display("FAIL raw_clear: busy=%h want 0", busy_o); end
    step();
    n_checks += 2;
    if (iss_if.iss_valid !== 1'b1 || iss_if.valu_opcode !== 5'd8)
      begin n_fail++; $display("FAIL raw_release: valid=%b op=%0d want 1 8", iss_if.iss_valid, iss_if.valu_opcode); end
    if (busy_o !== 32'h10) begin n_fail++; $display("FAIL raw_busy_v4: got %h want 10", busy_o); end
    step();
    retire(4);
  endtask

  task automatic test_back_to_back();
    logic [4:0] got_op[$];
    logic [4:0] got_wb[$];
    bit acc;
    iss_if.iss_ready = 0;
    inst_valid_i = 1; inst_i = enc(5, 10, 11, 0, 20, 7'b1010111);
    step();
    inst_i = enc(6, 12, 13, 0, 21, 7'b1010111);
    step();
    inst_i = enc(1, 14, 15, 0, 22, 7'b1010111);
    for (int c = 0; c < 3; c++) begin
      n_checks += 3;
      if (inst_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready: cycle %0d got %b want 0", c, inst_ready_o); end
      if (iss_if.iss_valid !== 1'b1 || iss_if.valu_opcode !== 5'd6)
        begin n_fail++; $display("FAIL bp_hold_op: valid=%b op=%0d want 1 6", iss_if.iss_valid, iss_if.valu_opcode); end
      if (iss_if.operand_v1 !== vrf[11] || iss_if.vid_wb_addr !== 5'd20)
        begin n_fail++; $display("FAIL bp_hold_data: v1=%h wb=%0d", iss_if.operand_v1, iss_if.vid_wb_addr); end
      step();
    end
    iss_if.iss_ready = 1;
    for (int c = 0; c < 20 && got_op.size() < 3; c++) begin
      @(negedge clk);
      if (iss_if.iss_valid) begin got_op.push_back(iss_if.valu_opcode); got_wb.push_back(iss_if.vid_wb_addr); end
      acc = inst_valid_i && inst_ready_o;
      step();
      if (acc) inst_valid_i = 0;
    end
    n_checks += 2;
    if (got_op.size() != 3) begin n_fail++; $display("FAIL bp_count: got %0d issues want 3", got_op.size()); end
    else if (got_op[0] !== 5'd6 || got_op[1] !== 5'd7 || got_op[2] !== 5'd2)
      begin n_fail++; $display("FAIL bp_order: got %0d %0d %0d want 6 7 2", got_op[0], got_op[1], got_op[2]); end
    if (busy_o !== 32'h0070_0000) begin n_fail++; $display("FAIL bp_busy: got %h want 00700000", busy_o); end
    inst_valid_i = 0;
    retire(20); retire(21); retire(22);
  endtask

  task automatic test_illegal();
    logic [31:0] seq [2];
    int idx = 0, pulses = 0;
    bit seen_iss = 0, acc;
    seq[0] = enc(5, 1, 2, 1, 7, 7'b1010111);
    seq[1] = enc(14, 1, 2, 0, 8, 7'b1010111);
    iss_if.iss_ready = 1;
    inst_valid_i = 1; inst_i = seq[0];
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (illegal_o) pulses++;
      if (iss_if.iss_valid) seen_iss = 1;
      acc = inst_valid_i && inst_ready_o;
      step();
      if (acc) begin
        idx++;
        if (idx < 2) inst_i = seq[idx]; else inst_valid_i = 0;
      end
    end
    n_checks += 3;
    if (pulses != 2) begin n_fail++; $display("FAIL illegal_pulses: got %0d want 2", pulses); end
    if (seen_iss) begin n_fail++; $display("FAIL illegal_issued: got iss_valid 1 want 0"); end
    if (busy_o !== 32'h0) begin n_fail++; $display("FAIL illegal_busy: got %h want 0", busy_o); end
  endtask

  task automatic test_random();
    exp_t exp_q[$];
    int pend[$];
    int n_ill_exp = 0, n_ill = 0, quiet = 0, fin = 0;
    bit sender_done = 0;
    logic [31:0] prog[$];
    for (int i = 0; i < 60; i++) begin
      int sel, f3;
      logic [6:0] opc;
      exp_t e;
      sel = $urandom_range(0, 9);
      opc = (sel < 2) ? 7'b0000111 : (sel < 4) ? 7'b0100111 : (sel < 9) ? 7'b1010111 : 7'($urandom());
      case ($urandom_range(0, 4))
        0: f3 = 0; 1: f3 = 4; 2: f3 = 3; default: f3 = $urandom_range(0, 7);
      endcase
      prog.push_back(enc($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                         f3, $urandom_range(0, 7), opc));
      e = predict(prog[i]);
      if (e.legal) exp_q.push_back(e); else n_ill_exp++;
    end
    fork
      begin
        foreach (prog[i]) send(prog[i]);
        sender_done = 1;
      end
      begin
        for (int c = 0; c < 5000 && !fin; c++) begin
          iss_if.iss_ready = ($urandom_range(0, 9) < 7);
          if (pend.size() > 0 && $urandom_range(0, 9) < 4) begin
            int k = $urandom_range(0, pend.size() - 1);
            wb_valid_i = 1; wb_addr_i = 5'(pend[k]);
            pend.delete(k);
          end else wb_valid_i = 0;
          @(negedge clk);
          if (illegal_o) n_ill++;
          if (iss_if.iss_valid && iss_if.iss_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL rnd_extra_issue: got op %0d want none", iss_if.valu_opcode);
            end else begin
              exp_t e = exp_q.pop_front();
              n_checks += 4;
              if ({iss_if.vmem_ren, iss_if.vmem_wen, iss_if.vid_wb_en, iss_if.vid_wb_sel, iss_if.vid_wb_addr, iss_if.valu_opcode}
                  !== {e.ren, e.wen, e.wb_en, e.sel, e.wb_addr, e.op})
                begin n_fail++; $display("FAIL rnd_ctrl: got ren%b wen%b wb%b sel%b wa%0d op%0d want ren%b wen%b wb%b sel%b wa%0d op%0d",
                  iss_if.vmem_ren, iss_if.vmem_wen, iss_if.vid_wb_en, iss_if.vid_wb_sel, iss_if.vid_wb_addr, iss_if.valu_opcode,
                  e.ren, e.wen, e.wb_en, e.sel, e.wb_addr, e.op); end
              if (iss_if.operand_v1 !== e.v1) begin n_fail++; $display("FAIL rnd_v1: got %h want %h", iss_if.operand_v1, e.v1); end
              if (iss_if.operand_v2 !== e.v2) begin n_fail++; $display("FAIL rnd_v2: got %h want %h", iss_if.operand_v2, e.v2); end
              if (iss_if.vmem_addr !== e.addr || iss_if.vmem_din !== e.din)
                begin n_fail++; $display("FAIL rnd_mem: got addr %h din %h want %h %h", iss_if.vmem_addr, iss_if.vmem_din, e.addr, e.din); end
            end
            if (iss_if.vid_wb_en) pend.push_back(int'(iss_if.vid_wb_addr));
          end
          if (sender_done && exp_q.size() == 0 && pend.size() == 0) quiet++; else quiet = 0;
          if (quiet >= 3) fin = 1;
          step();
        end
        wb_valid_i = 0;
      end
    join
    n_checks += 3;
    if (!fin) begin n_fail++; $display("FAIL rnd_timeout: %0d ops still expected, %0d pending wb", exp_q.size(), pend.size()); end
    if (n_ill != n_ill_exp) begin n_fail++; $display("FAIL rnd_illegal_count: got %0d want %0d", n_ill, n_ill_exp); end
    step();
    if (busy_o !== 32'h0) begin n_fail++; $display("FAIL rnd_busy_final: got %h want 0", busy_o); end
  endtask

  task automatic test_reset_flush();
    iss_if.iss_ready = 1;
    send(enc(5, 2, 1, 0, 3, 7'b1010111));
    send(enc(5, 2, 1, 0, 4, 7'b1010111));
    send(enc(5, 3, 1, 0, 9, 7'b1010111));
    step();
    n_checks++;
    if (busy_o !== 32'h18) begin n_fail++; $display("FAIL rf_busy_pre: got %h want 00000018", busy_o); end
    #2 rst = 0;
    #1;
    n_checks += 2;
    if (busy_o !== 32'h0) begin n_fail++; $display("FAIL rf_async_busy: got %h want 0", busy_o); end
    if (iss_if.iss_valid !== 1'b0 || illegal_o !== 1'b0)
      begin n_fail++; $display("FAIL rf_async_valid: valid=%b illegal=%b want 0 0", iss_if.iss_valid, illegal_o); end
    @(negedge clk); rst = 1;
    step();
    n_checks++;
    if (inst_ready_o !== 1'b1 || iss_if.iss_valid !== 1'b0)
      begin n_fail++; $display("FAIL rf_after_reset: ready=%b valid=%b want 1 0", inst_ready_o, iss_if.iss_valid); end
    inst_valid_i = 1; inst_i = enc(5, 2, 1, 0, 3, 7'b1010111); flush_i = 1;
    step();
    inst_valid_i = 0; flush_i = 0;
    step();
    n_checks += 2;
    if (iss_if.iss_valid !== 1'b0) begin n_fail++; $display("FAIL rf_flush_accept: iss_valid=%b want 0", iss_if.iss_valid); end
    if (busy_o !== 32'h0) begin n_fail++; $display("FAIL rf_flush_accept_busy: got %h want 0", busy_o); end
    iss_if.iss_ready = 0;
    send(enc(5, 2, 1, 0, 3, 7'b1010111));
    step();
    flush_i = 1;
    step();
    flush_i = 0;
    n_checks += 2;
    if (iss_if.iss_valid !== 1'b0) begin n_fail++; $display("FAIL rf_flush_i: iss_valid=%b want 0", iss_if.iss_valid); end
    if (busy_o !== 32'h8) begin n_fail++; $display("FAIL rf_flush_keeps_sb: got %h want 00000008", busy_o); end
    retire(3);
  endtask

  initial begin
    rst = 0; flush_i = 0; inst_valid_i = 0; inst_i = '0;
    wb_valid_i = 0; wb_addr_i = '0; iss_if.iss_ready = 0;
    for (int i = 0; i < 32; i++) begin
      for (int w = 0; w < 16; w++) vrf[i][32*w +: 32] = $urandom();
      srf[i] = {$urandom(), $urandom()};
    end
    repeat (3) @(posedge clk);
    #1 rst = 1;
    step();
    test_reset();
    test_vadd();
    test_widen_vx();
    test_raw_stall();
    test_back_to_back();
    test_illegal();
    test_random();
    test_reset_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
